// File: rtl/mdu_iter_pkg.sv
// Shared types for the iterative multiply/divide unit.
// Latency: none (types and pure functions only).
// Backpressure: n/a.
package mdu_pkg;

  typedef enum logic [3:0] {
    NOP,
    READ_LO,
    READ_HI,
    WRITE_LO,
    WRITE_HI,
    MUL_S,
    MUL_U,
    MADD_S,
    MADD_U,
    MSUB_S,
    MSUB_U,
    DIV_S,
    DIV_U
  } mdu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIX
  } mdu_state_t;

  // Ops that start an iteration (multiply, accumulate or divide).
  function automatic logic mdu_is_start(input mdu_op_t op);
    return (op >= MUL_S) && (op <= DIV_U);
  endfunction

  // Ops whose operands are two's complement.
  function automatic logic mdu_is_signed(input mdu_op_t op);
    return (op == MUL_S) || (op == MADD_S) || (op == MSUB_S) || (op == DIV_S);
  endfunction

  function automatic logic mdu_is_div(input mdu_op_t op);
    return (op == DIV_S) || (op == DIV_U);
  endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
// Latency: none (wires only).
// Backpressure: requester must hold off while busy_o is high.
interface mdu_iter_if #(
  parameter int WIDTH = 32
);
  import mdu_pkg::*;

  logic             valid_i;
  mdu_op_t          op_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             flush_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] rdata_o;

  modport master (
    output valid_i, op_i, a_i, b_i, flush_i,
    input  busy_o, done_o, rdata_o
  );

  modport slave (
    input  valid_i, op_i, a_i, b_i, flush_i,
    output busy_o, done_o, rdata_o
  );

endinterface

// File: rtl/mdu_div_stage.sv
// One restoring-division step: shift in a dividend bit, trial subtract, select.
// Latency: combinational.
// Backpressure: none.
module mdu_div_stage #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;

  // Partial remainder with the next dividend bit (MSB of the quotient reg) appended.
  assign w_shift = {i_rem, i_quo[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, i_div});
  // When w_ge holds the true difference is below the divisor, so WIDTH bits suffice.
  assign w_diff  = w_shift[WIDTH-1:0] - i_div;
  assign o_rem   = w_ge ? w_diff : w_shift[WIDTH-1:0];
  assign o_quo   = {i_quo[WIDTH-2:0], w_ge};

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with MADD/MSUB, HI/LO registers and flush.
// Latency: WIDTH/STEP RUN cycles + 1 FIX cycle; done_o the cycle after commit.
// Backpressure: busy_o high while iterating; requests presented then are dropped.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input logic       clk,
  input logic       rst,
  mdu_iter_if.slave mdu
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_RUN  = ST_RUN;
  localparam logic [1:0] S_FIX  = ST_FIX;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  mdu_op_t          r_op;
  logic             r_sa;
  logic             r_sb;
  logic [WIDTH-1:0] r_opd;   // multiplicand or divisor magnitude
  logic [WIDTH-1:0] r_wh;    // product high half / partial remainder
  logic [WIDTH-1:0] r_wl;    // multiplier then product low half / quotient
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_busy;
  logic             r_done;

  logic             w_accept;
  logic             w_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;

  // A flush in the same cycle as a request cancels that request too.
  assign w_accept = mdu.valid_i & ~r_busy & ~mdu.flush_i;
  assign w_signed = mdu_is_signed(mdu.op_i);
  assign w_a_neg  = w_signed & mdu.a_i[WIDTH-1];
  assign w_b_neg  = w_signed & mdu.b_i[WIDTH-1];
  assign w_a_mag  = w_a_neg ? (~mdu.a_i + 1'b1) : mdu.a_i;
  assign w_b_mag  = w_b_neg ? (~mdu.b_i + 1'b1) : mdu.b_i;

  // Shift-add multiply: STEP multiplier bits retired per cycle.
  logic [WIDTH:0]   v_t;
  logic [WIDTH-1:0] v_h;
  logic [WIDTH-1:0] v_l;
  always_comb begin
    v_h = r_wh;
    v_l = r_wl;
    v_t = '0;
    for (int i = 0; i < STEP; i++) begin
      v_t = {1'b0, v_h} + (v_l[0] ? {1'b0, r_opd} : {(WIDTH+1){1'b0}});
      v_l = {v_t[0], v_l[WIDTH-1:1]};
      v_h = v_t[WIDTH:1];
    end
  end

  // Restoring divide: STEP chained stages per cycle.
  logic [WIDTH-1:0] w_rem [0:STEP];
  logic [WIDTH-1:0] w_quo [0:STEP];
  assign w_rem[0] = r_wh;
  assign w_quo[0] = r_wl;
  for (genvar g = 0; g < STEP; g++) begin : g_div
    mdu_div_stage #(.WIDTH(WIDTH)) u_stage (
      .i_rem (w_rem[g]),
      .i_quo (w_quo[g]),
      .i_div (r_opd),
      .o_rem (w_rem[g+1]),
      .o_quo (w_quo[g+1])
    );
  end

  logic             w_is_div;
  logic [WIDTH-1:0] w_it_h;
  logic [WIDTH-1:0] w_it_l;
  assign w_is_div = mdu_is_div(r_op);
  assign w_it_h   = w_is_div ? w_rem[STEP] : v_h;
  assign w_it_l   = w_is_div ? w_quo[STEP] : v_l;

  // Sign restoration and accumulation applied on the FIX edge.
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [WIDTH-1:0]   w_quo_s;
  logic [WIDTH-1:0]   w_rem_s;
  logic [2*WIDTH-1:0] w_res;
  assign w_prod   = {r_wh, r_wl};
  assign w_prod_s = (r_sa ^ r_sb) ? (~w_prod + 1'b1) : w_prod;
  assign w_quo_s  = (r_sa ^ r_sb) ? (~r_wl + 1'b1) : r_wl;
  // Remainder follows the dividend; with a zero divisor it is the dividend itself.
  assign w_rem_s  = r_sa ? (~r_wh + 1'b1) : r_wh;

  // Select the value committed to {HI,LO} according to the latched op.
  always_comb begin
    w_res = w_prod_s;
    unique case (r_op)
      MADD_S, MADD_U: w_res = {r_hi, r_lo} + w_prod_s;
      MSUB_S, MSUB_U: w_res = {r_hi, r_lo} - w_prod_s;
      DIV_S, DIV_U:   w_res = {w_rem_s, (r_opd == '0) ? {WIDTH{1'b1}} : w_quo_s};
      default:        w_res = w_prod_s;
    endcase
  end

  // FSM, working registers, HI/LO and status flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= NOP;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_opd   <= '0;
      r_wh    <= '0;
      r_wl    <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (mdu.op_i == WRITE_HI) r_hi <= mdu.a_i;
            if (mdu.op_i == WRITE_LO) r_lo <= mdu.a_i;
            if (mdu_is_start(mdu.op_i)) begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
              r_cnt   <= CW'(N);
              r_op    <= mdu.op_i;
              r_sa    <= w_a_neg;
              r_sb    <= w_b_neg;
              r_wh    <= '0;
              if (mdu_is_div(mdu.op_i)) begin
                r_opd <= w_b_mag;
                r_wl  <= w_a_mag;
              end else begin
                r_opd <= w_a_mag;
                r_wl  <= w_b_mag;
              end
            end
          end
        end
        S_RUN: begin
          if (mdu.flush_i) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_wh  <= w_it_h;
            r_wl  <= w_it_l;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CW'(1)) r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          if (!mdu.flush_i) begin
            {r_hi, r_lo} <= w_res;
            r_done       <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign mdu.busy_o  = r_busy;
  assign mdu.done_o  = r_done;
  assign mdu.rdata_o = (mdu.op_i == READ_HI) ? r_hi : r_lo;

endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter: STEP=1 and STEP=4 instances driven in parallel.
// Directed cases from the operation rules, then random ops against a reference model.
// Results read in the done_o cycle; busy/done timing checked per instance.
module tb_mdu_iter;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mdu_iter_if #(.WIDTH(32)) bus1 ();
  mdu_iter_if #(.WIDTH(32)) bus4 ();

  mdu_iter #(.WIDTH(32), .STEP(1)) dut1 (.clk(clk), .rst(rst), .mdu(bus1));
  mdu_iter #(.WIDTH(32), .STEP(4)) dut4 (.clk(clk), .rst(rst), .mdu(bus4));

  int tests = 0;
  int fails = 0;
  logic [31:0] m_hi, m_lo;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input mdu_op_t op, input logic [31:0] a, input logic [31:0] b,
                       input logic fl);
    bus1.valid_i = v; bus1.op_i = op; bus1.a_i = a; bus1.b_i = b; bus1.flush_i = fl;
    bus4.valid_i = v; bus4.op_i = op; bus4.a_i = a; bus4.b_i = b; bus4.flush_i = fl;
  endtask

  task automatic read_check(input int k, input string tag, input logic [31:0] ehi,
                            input logic [31:0] elo);
    if (k == 0) begin
      bus1.op_i = READ_HI; #1; check({tag, " hi s1"}, 64'(bus1.rdata_o), 64'(ehi));
      bus1.op_i = READ_LO; #1; check({tag, " lo s1"}, 64'(bus1.rdata_o), 64'(elo));
      bus1.op_i = NOP;
    end else begin
      bus4.op_i = READ_HI; #1; check({tag, " hi s4"}, 64'(bus4.rdata_o), 64'(ehi));
      bus4.op_i = READ_LO; #1; check({tag, " lo s4"}, 64'(bus4.rdata_o), 64'(elo));
      bus4.op_i = NOP;
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural HI/LO pair.
  function automatic void model(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b,
                                inout logic [31:0] hi, inout logic [31:0] lo);
    logic [63:0] acc, p;
    int sa, sb;
    acc = {hi, lo};
    sa = $signed(a);
    sb = $signed(b);
    if (op == MUL_S || op == MADD_S || op == MSUB_S) p = 64'(longint'(sa) * longint'(sb));
    else p = {32'b0, a} * {32'b0, b};
    case (op)
      WRITE_HI: hi = a;
      WRITE_LO: lo = a;
      MUL_S, MUL_U: {hi, lo} = p;
      MADD_S, MADD_U: {hi, lo} = acc + p;
      MSUB_S, MSUB_U: {hi, lo} = acc - p;
      DIV_U: begin
        if (b == 0) begin lo = '1; hi = a; end
        else begin lo = a / b; hi = a % b; end
      end
      DIV_S: begin
        if (b == 0) begin lo = '1; hi = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lo = a; hi = 0; end
        else begin lo = 32'(sa / sb); hi = 32'(sa % sb); end
      end
      default: ;
    endcase
  endfunction

  // Issue one iterating op to both units and check timing and result in the done cycle.
  task automatic run_op(input string tag, input mdu_op_t op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int busy_n[2] = '{0, 0};
    int done_n[2] = '{0, 0};
    int done_at[2] = '{0, 0};
    @(negedge clk); drive(1'b1, op, a, b, 1'b0);
    @(negedge clk); drive(1'b0, NOP, '0, '0, 1'b0);
    for (int c = 1; c <= 40; c++) begin
      if (bus1.busy_o) busy_n[0]++;
      if (bus4.busy_o) busy_n[1]++;
      if (bus1.done_o) begin done_n[0]++; done_at[0] = c; read_check(0, tag, ehi, elo); end
      if (bus4.done_o) begin done_n[1]++; done_at[1] = c; read_check(1, tag, ehi, elo); end
      @(negedge clk);
    end
    check({tag, " busy s1"}, 64'(busy_n[0]), 64'd33);
    check({tag, " done at s1"}, 64'(done_at[0]), 64'd34);
    check({tag, " done cnt s1"}, 64'(done_n[0]), 64'd1);
    check({tag, " busy s4"}, 64'(busy_n[1]), 64'd9);
    check({tag, " done at s4"}, 64'(done_at[1]), 64'd10);
    check({tag, " done cnt s4"}, 64'(done_n[1]), 64'd1);
  endtask

  task automatic run_write(input string tag, input mdu_op_t op, input logic [31:0] a,
                           input logic [31:0] ehi, input logic [31:0] elo);
    @(negedge clk); drive(1'b1, op, a, '0, 1'b0);
    @(negedge clk); drive(1'b0, NOP, '0, '0, 1'b0);
    check({tag, " busy"}, {62'b0, bus1.busy_o, bus4.busy_o}, 64'd0);
    check({tag, " done"}, {62'b0, bus1.done_o, bus4.done_o}, 64'd0);
    read_check(0, tag, ehi, elo);
    read_check(1, tag, ehi, elo);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int d1, d4;
    mdu_op_t ops[10] = '{WRITE_LO, WRITE_HI, MUL_S, MUL_U, MADD_S, MADD_U, MSUB_S, MSUB_U,
                         DIV_S, DIV_U};
    rst = 1'b0;
    drive(1'b0, NOP, '0, '0, 1'b0);
    repeat (3) @(negedge clk);
    check("reset busy", {62'b0, bus1.busy_o, bus4.busy_o}, 64'd0);
    check("reset done", {62'b0, bus1.done_o, bus4.done_o}, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    read_check(0, "reset", 32'h0, 32'h0);
    read_check(1, "reset", 32'h0, 32'h0);

    run_op("mul_s -3*7", MUL_S, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("div_s -7/2", DIV_S, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_u 7/0", DIV_U, 32'd7, 32'd0, 32'h0000_0007, 32'hFFFF_FFFF);
    run_op("div_s min/-1", DIV_S, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    run_op("div_s -7/0", DIV_S, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_write("write_hi", WRITE_HI, 32'h0, 32'h0, 32'hFFFF_FFFF);
    run_write("write_lo", WRITE_LO, 32'd10, 32'h0, 32'd10);
    run_op("madd_u 3*4", MADD_U, 32'd3, 32'd4, 32'h0, 32'd22);
    run_op("msub_s 5*5", MSUB_S, 32'd5, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // Flush in the 10th busy cycle of the STEP=1 unit; STEP=4 finishes first.
    d1 = 0; d4 = 0;
    @(negedge clk); drive(1'b1, MUL_U, 32'h1234, 32'h5678, 1'b0);
    @(negedge clk); drive(1'b0, NOP, '0, '0, 1'b0);
    for (int c = 1; c <= 45; c++) begin
      if (c == 5) drive(1'b1, MUL_U, 32'd9, 32'd9, 1'b0);
      if (c == 6) drive(1'b0, NOP, '0, '0, 1'b0);
      if (c == 10) drive(1'b0, NOP, '0, '0, 1'b1);
      if (c == 11) begin
        drive(1'b0, NOP, '0, '0, 1'b0);
        check("flush idle s1", {63'b0, bus1.busy_o}, 64'd0);
      end
      if (bus1.done_o) d1++;
      if (bus4.done_o) d4++;
      @(negedge clk);
    end
    check("flush done s1", 64'(d1), 64'd0);
    check("flush done s4", 64'(d4), 64'd1);
    read_check(0, "flush", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    read_check(1, "mid-busy op", 32'h0, 32'h0626_0060);

    // Reset pulled mid-RUN.
    @(negedge clk); drive(1'b1, DIV_U, 32'hFFFF_FFFF, 32'd16, 1'b0);
    @(negedge clk); drive(1'b0, NOP, '0, '0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("rst mid-run busy", {62'b0, bus1.busy_o, bus4.busy_o}, 64'd0);
    read_check(0, "rst mid-run", 32'h0, 32'h0);
    read_check(1, "rst mid-run", 32'h0, 32'h0);

    run_op("div_u ffffffff/16", DIV_U, 32'hFFFF_FFFF, 32'd16, 32'h0000_000F, 32'h0FFF_FFFF);

    m_hi = 32'h0000_000F;
    m_lo = 32'h0FFF_FFFF;
    for (int i = 0; i < 16; i++) begin
      mdu_op_t op;
      logic [31:0] a, b;
      op = ops[$urandom_range(0, 9)];
      a = pick_operand();
      b = pick_operand();
      model(op, a, b, m_hi, m_lo);
      if (op == WRITE_HI || op == WRITE_LO)
        run_write($sformatf("rnd%0d %s", i, op.name()), op, a, m_hi, m_lo);
      else
        run_op($sformatf("rnd%0d %s %h %h", i, op.name(), a, b), op, a, b, m_hi, m_lo);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
